// File: rtl/sp_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sp_ram_pkg
//  Purpose  : Shared types and RAM control-pin encodings for sp_ram_req_ctrl
//  Revision : 1.0  initial release
// ============================================================================
package sp_ram_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    CAP  = 2'd3
  } state_t;

  // RAM control pins packed as {cs, we, oe}
  localparam logic [2:0] CTRL_OFF   = 3'b000;
  localparam logic [2:0] CTRL_WRITE = 3'b110;
  localparam logic [2:0] CTRL_READ  = 3'b101;

  // Control pins to present while the controller sits in a given state.
  // CAP repeats the read encoding so the RAM keeps driving the bus.
  function automatic logic [2:0] ctrl_for(input state_t s);
    logic [2:0] c;
    c = CTRL_OFF;
    case (s)
      WR:      c = CTRL_WRITE;
      RD:      c = CTRL_READ;
      CAP:     c = CTRL_READ;
      default: c = CTRL_OFF;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sp_ram_req_ctrl
//  Purpose  : Valid/ready request/response front end for a single-port
//             synchronous RAM; drives addr/cs/we/oe and the shared data bus
//  Revision : 1.0  initial release
// ============================================================================
module sp_ram_req_ctrl
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  wr_drop,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state;
  state_t                next_state;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept;
  logic                  in_range;

  assign req_ready = (state == IDLE) && !rsp_valid;
  assign accept    = req_valid && req_ready;
  assign in_range  = ({1'b0, req_addr} < DEPTH_W);

  // Bus is owned by the controller only during the WR cycle
  assign ram_data = (state == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

  // Next-state selection; out-of-range requests never leave IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && in_range) next_state = req_we ? WR : RD;
      WR:      next_state = IDLE;
      RD:      next_state = CAP;
      CAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, registered RAM pins, request latch and response channel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      state                    <= next_state;
      {ram_cs, ram_we, ram_oe} <= ctrl_for(next_state);
      wr_drop                  <= accept && req_we && !in_range;

      if (accept && in_range) begin
        ram_addr <= req_addr;
        wdata_q  <= req_wdata;
      end

      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      // Out-of-range read answers immediately with an error and zero data
      if (accept && !req_we && !in_range) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end

      // RAM is driving registered read data during CAP
      if (state == CAP) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_rdata <= ram_data;
      end
    end
  end

endmodule
`default_nettype wire
